// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receive path.
//  - rx_state_t : receiver FSM state encoding
//  - calc_div   : clocks per oversample tick (integer truncation)
//  - UART_DATA_BITS / UART_IDLE_LEVEL : frame format constants
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Clocks between oversample ticks; truncates toward zero.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received bytes.
// Ports:
//  clk_i        system clock
//  rst_i        synchronous active-high reset (empties FIFO, clears storage)
//  push_i       write push_data_i; ignored when full unless a pop happens too
//  push_data_i  byte to store
//  pop_i        drop the head entry; ignored when empty
//  full_o       all DEPTH entries occupied
//  empty_o      no entries
//  head_o       entry at the read pointer (storage flop, no bypass)
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A simultaneous pop frees the slot, so a push while full still lands.
    assign do_pop_s  = pop_i & ~empty_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);

    // Pointer next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; cleared on reset so the head reads 0 afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver: synchronises the serial line, oversamples it, recovers
// bytes LSB-first and queues them in a FIFO presented as a valid/ready stream.
// Ports:
//  clk_clk          system clock
//  reset_reset      synchronous active-high reset
//  uart_rxd         asynchronous serial input, idle high
//  rx_data          FIFO head byte, meaningful while rx_valid=1
//  rx_valid         FIFO not empty
//  rx_ready         consumer takes the head when rx_valid & rx_ready
//  rx_framing_error 1-cycle pulse when the stop bit samples low
//  rx_overrun       1-cycle pulse when a byte completes into a full FIFO
//  rx_busy          receiver FSM not idle
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset,
    input  logic                      uart_rxd,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      rx_framing_error,
    output logic                      rx_overrun,
    output logic                      rx_busy
);

    localparam int DIV    = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(UART_DATA_BITS);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);
    localparam logic [SAMP_W-1:0] SAMP_ONE  = SAMP_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_START = START;
    localparam logic [2:0] S_DATA  = DATA;
    localparam logic [2:0] S_STOP  = STOP;
    localparam logic [2:0] S_BREAK = BREAK;

    logic                      sync1_q;
    logic                      sync2_q;
    logic                      prev_q;
    logic [2:0]                state_q;
    logic [2:0]                state_d;
    logic [DIV_W-1:0]          div_cnt_q;
    logic [DIV_W-1:0]          div_cnt_d;
    logic [SAMP_W-1:0]         samp_cnt_q;
    logic [SAMP_W-1:0]         samp_cnt_d;
    logic [BIT_W-1:0]          bit_idx_q;
    logic [BIT_W-1:0]          bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] shift_d;
    logic                      ferr_q;
    logic                      ferr_d;
    logic                      ovr_q;
    logic                      ovr_d;
    logic                      busy_q;
    logic                      busy_d;

    logic line_s;
    logic fall_s;
    logic tick_s;
    logic push_s;
    logic pop_s;
    logic full_s;
    logic empty_s;

    assign line_s = sync2_q;
    assign fall_s = prev_q & ~sync2_q;
    assign tick_s = (state_q != S_IDLE) && (div_cnt_q == DIV_LAST);

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q <= UART_IDLE_LEVEL;
            sync2_q <= UART_IDLE_LEVEL;
            prev_q  <= UART_IDLE_LEVEL;
        end else begin
            sync1_q <= uart_rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Tick divider: parked at 0 while idle so it restarts aligned to the start edge.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (state_q == S_IDLE) begin
            div_cnt_d = '0;
        end else if (tick_s) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_ONE;
        end
    end

    // Receiver FSM next-state and datapath.
    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        push_s     = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall_s) begin
                    state_d    = S_START;
                    samp_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s) begin
                    if (samp_cnt_q == SAMP_MID) begin
                        samp_cnt_d = '0;
                        // A start bit that is high again by mid-bit is a glitch.
                        if (line_s == UART_IDLE_LEVEL) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d   = S_DATA;
                            bit_idx_d = '0;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + SAMP_ONE;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (tick_s) begin
                    if (samp_cnt_q == SAMP_LAST) begin
                        samp_cnt_d = '0;
                        shift_d    = {line_s, shift_q[UART_DATA_BITS-1:1]};
                        if (bit_idx_q == BIT_LAST) begin
                            state_d = S_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + BIT_ONE;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + SAMP_ONE;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_STOP: begin
                if (tick_s) begin
                    if (samp_cnt_q == SAMP_LAST) begin
                        samp_cnt_d = '0;
                        if (line_s == UART_IDLE_LEVEL) begin
                            push_s  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        samp_cnt_d = samp_cnt_q + SAMP_ONE;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_BREAK: begin
                if (line_s == UART_IDLE_LEVEL) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs registered alongside the state they describe.
    always_comb begin
        ovr_d  = push_s & full_s & ~pop_s;
        busy_d = (state_d != S_IDLE);
    end

    // FSM, counter and status registers.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            samp_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign pop_s = rx_valid & rx_ready;

    uart_rx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_clk),
        .rst_i       (reset_reset),
        .push_i      (push_s),
        .push_data_i (shift_q),
        .pop_i       (pop_s),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .head_o      (rx_data)
    );

    assign rx_valid         = ~empty_s;
    assign rx_framing_error = ferr_q;
    assign rx_overrun       = ovr_q;
    assign rx_busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer at default parameters (432 clocks per bit).
module tb_uart_rx_framer;

    localparam int BIT = 432;

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_framing_error;
    logic       rx_overrun;
    logic       rx_busy;

    int n_checks = 0;
    int n_fail   = 0;

    int         valid_cycles = 0;
    int         ferr_cnt     = 0;
    int         ovr_cnt      = 0;
    logic [7:0] got_q[$];

    always #5 clk_clk = ~clk_clk;

    uart_rx_framer dut (
        .clk_clk          (clk_clk),
        .reset_reset      (reset_reset),
        .uart_rxd         (uart_rxd),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .rx_framing_error (rx_framing_error),
        .rx_overrun       (rx_overrun),
        .rx_busy          (rx_busy)
    );

    // Event monitor on the inactive edge: counts pulses and records accepted bytes.
    always @(negedge clk_clk) begin
        if (rx_valid) valid_cycles++;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (rx_framing_error) ferr_cnt++;
        if (rx_overrun) ovr_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tk(input int n);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic v);
        uart_rxd = v;
        tk(BIT);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_lvl);
    endtask

    int v0, f0, o0, g0;

    initial begin
        reset_reset = 1'b1;
        uart_rxd    = 1'b1;
        rx_ready    = 1'b1;
        tk(3);
        check_val("rst_valid", 32'(rx_valid), 32'd0);
        check_val("rst_data", 32'(rx_data), 32'h00);
        check_val("rst_busy", 32'(rx_busy), 32'd0);
        check_val("rst_ferr", 32'(rx_framing_error), 32'd0);
        check_val("rst_ovr", 32'(rx_overrun), 32'd0);
        reset_reset = 1'b0;
        tk(5);

        // 1: single clean frame
        v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt; g0 = got_q.size();
        send_frame(8'h41, 1'b1);
        tk(20);
        check_val("t1_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check_val("t1_count", 32'(got_q.size() - g0), 32'd1);
        if (got_q.size() > g0) check_val("t1_data", 32'(got_q[g0]), 32'h41);
        check_val("t1_ferr", 32'(ferr_cnt - f0), 32'd0);
        check_val("t1_ovr", 32'(ovr_cnt - o0), 32'd0);
        check_val("t1_busy", 32'(rx_busy), 32'd0);

        // 2: short low glitch rejected at mid start bit
        v0 = valid_cycles; f0 = ferr_cnt;
        uart_rxd = 1'b0;
        tk(50);
        check_val("t2_busy_in", 32'(rx_busy), 32'd1);
        tk(50);
        uart_rxd = 1'b1;
        tk(300);
        check_val("t2_busy_out", 32'(rx_busy), 32'd0);
        check_val("t2_valid_cycles", 32'(valid_cycles - v0), 32'd0);
        check_val("t2_ferr", 32'(ferr_cnt - f0), 32'd0);

        // 3: stop bit low, line held low afterwards
        v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'hA5, 1'b0);
        tk(2 * BIT);
        check_val("t3_ferr", 32'(ferr_cnt - f0), 32'd1);
        check_val("t3_valid_cycles", 32'(valid_cycles - v0), 32'd0);
        check_val("t3_ovr", 32'(ovr_cnt - o0), 32'd0);
        check_val("t3_busy_break", 32'(rx_busy), 32'd1);
        uart_rxd = 1'b1;
        tk(10);
        check_val("t3_busy_idle", 32'(rx_busy), 32'd0);

        // 4: fill FIFO with consumer stalled, fifth byte overruns
        rx_ready = 1'b0;
        f0 = ferr_cnt; o0 = ovr_cnt; g0 = got_q.size();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        tk(5);
        check_val("t4_ovr", 32'(ovr_cnt - o0), 32'd1);
        check_val("t4_valid", 32'(rx_valid), 32'd1);
        check_val("t4_head", 32'(rx_data), 32'h01);
        check_val("t4_ferr", 32'(ferr_cnt - f0), 32'd0);
        rx_ready = 1'b1;
        tk(10);
        check_val("t4_drain_count", 32'(got_q.size() - g0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (got_q.size() > g0 + i) check_val("t4_drain_data", 32'(got_q[g0 + i]), 32'(i + 1));
        end
        check_val("t4_valid_after", 32'(rx_valid), 32'd0);
        check_val("t4_ovr_total", 32'(ovr_cnt - o0), 32'd1);

        // 5: reset mid-frame with a byte already buffered
        rx_ready = 1'b0;
        f0 = ferr_cnt;
        send_frame(8'h77, 1'b1);
        tk(5);
        check_val("t5_pre_valid", 32'(rx_valid), 32'd1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        uart_rxd = 1'b1;
        tk(BIT / 2);
        reset_reset = 1'b1;
        tk(1);
        check_val("t5_rst_valid", 32'(rx_valid), 32'd0);
        check_val("t5_rst_busy", 32'(rx_busy), 32'd0);
        check_val("t5_rst_data", 32'(rx_data), 32'h00);
        check_val("t5_rst_ferr", 32'(rx_framing_error), 32'd0);
        check_val("t5_rst_ovr", 32'(rx_overrun), 32'd0);
        reset_reset = 1'b0;
        rx_ready    = 1'b1;
        tk(BIT);
        g0 = got_q.size();
        send_frame(8'h5A, 1'b1);
        tk(20);
        check_val("t5_count", 32'(got_q.size() - g0), 32'd1);
        if (got_q.size() > g0) check_val("t5_data", 32'(got_q[g0]), 32'h5A);
        check_val("t5_ferr", 32'(ferr_cnt - f0), 32'd0);

        // 6: back-to-back frames with no idle gap
        f0 = ferr_cnt; o0 = ovr_cnt; g0 = got_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tk(20);
        check_val("t6_count", 32'(got_q.size() - g0), 32'd2);
        if (got_q.size() > g0) check_val("t6_data0", 32'(got_q[g0]), 32'h00);
        if (got_q.size() > g0 + 1) check_val("t6_data1", 32'(got_q[g0 + 1]), 32'hFF);
        check_val("t6_ferr", 32'(ferr_cnt - f0), 32'd0);
        check_val("t6_ovr", 32'(ovr_cnt - o0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
